// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, reads a combinational program memory
// and issues each word to the datapath over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for Fetch_Start after reset
// FETCH | PC on the bus, capture the returned word
// ISSUE | Instr_Valid high until the datapath accepts
// HALT  | zero word fetched; waiting for restart
module fetch_sequencer #(
   parameter int                         DATAWIDTH_BUS = 32,
   parameter logic [DATAWIDTH_BUS-1:0]   RESET_PC      = 32'h00000800,
   parameter int                         CNT_WIDTH     = 16
) (
   input  logic                     CLOCK_50,
   input  logic                     RESET_InHigh,
   input  logic                     Fetch_Start,
   output logic [DATAWIDTH_BUS-1:0] BusDirecciones,
   input  logic [DATAWIDTH_BUS-1:0] BusDatos,
   output logic [DATAWIDTH_BUS-1:0] Instr_Out,
   output logic [DATAWIDTH_BUS-1:0] PC_Out,
   output logic                     Instr_Valid,
   input  logic                     Instr_Ready,
   input  logic                     Branch_Taken,
   input  logic [DATAWIDTH_BUS-1:0] Branch_Disp,
   output logic                     Busy,
   output logic                     Halted,
   output logic [CNT_WIDTH-1:0]     Issue_Count
);

   typedef enum logic [1:0] {IDLE, FETCH, ISSUE, HALT} state_t;

   state_t                   state, state_nxt;
   logic [DATAWIDTH_BUS-1:0] pc, ir, ir_addr, instr_q, pc_out_q;
   logic [CNT_WIDTH-1:0]     issue_count;

   always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
      if (RESET_InHigh) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         ir          <= '0;
         ir_addr     <= RESET_PC;
         instr_q     <= '0;
         pc_out_q    <= RESET_PC;
         issue_count <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (Fetch_Start) issue_count <= '0;
            end
            FETCH: begin
               ir      <= BusDatos;
               ir_addr <= pc;
               // Issue-side copies only move for a real instruction so the
               // outputs keep their last issued values through HALT.
               if (BusDatos != '0) begin
                  instr_q  <= BusDatos;
                  pc_out_q <= pc;
               end
            end
            ISSUE: begin
               if (Instr_Ready) begin
                  issue_count <= issue_count + CNT_WIDTH'(1);
                  pc          <= ir_addr + (Branch_Taken ? Branch_Disp
                                                         : DATAWIDTH_BUS'(1));
               end
            end
            HALT: begin
               if (Fetch_Start) begin
                  pc          <= RESET_PC;
                  issue_count <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Fetch_Start) state_nxt = FETCH;
         FETCH:   state_nxt = (BusDatos == '0) ? HALT : ISSUE;
         ISSUE:   if (Instr_Ready) state_nxt = FETCH;
         HALT:    if (Fetch_Start) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      BusDirecciones = pc;
      Instr_Out      = instr_q;
      PC_Out         = pc_out_q;
      Issue_Count    = issue_count;
      Instr_Valid    = (state == ISSUE);
      Busy           = (state == FETCH) || (state == ISSUE);
      Halted         = (state == HALT);
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: main instance at RESET_PC=0x800 plus a
// second instance at RESET_PC=0xFFFFFFFF for the address wrap case.
module tb_fetch_sequencer;

   logic        CLOCK_50 = 1'b0;
   logic        RESET_InHigh = 1'b0;
   logic        Fetch_Start = 1'b0;
   logic [31:0] BusDirecciones, BusDatos, Instr_Out, PC_Out, Branch_Disp = '0;
   logic        Instr_Valid, Instr_Ready = 1'b0, Branch_Taken = 1'b0, Busy, Halted;
   logic [15:0] Issue_Count;

   logic        start_w = 1'b0;
   logic [31:0] bus_w, dat_w, instr_w, pc_w;
   logic        valid_w, busy_w, halted_w;
   logic [15:0] count_w;

   logic [31:0] zero_addr = 32'h0000080E;
   int chk = 0;
   int fail = 0;

   always #5 CLOCK_50 = ~CLOCK_50;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A000000;
   endfunction

   always_comb BusDatos = (BusDirecciones == zero_addr) ? 32'h0 : mem_word(BusDirecciones);
   always_comb dat_w = mem_word(bus_w);

   fetch_sequencer dut (
      .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh), .Fetch_Start(Fetch_Start),
      .BusDirecciones(BusDirecciones), .BusDatos(BusDatos), .Instr_Out(Instr_Out),
      .PC_Out(PC_Out), .Instr_Valid(Instr_Valid), .Instr_Ready(Instr_Ready),
      .Branch_Taken(Branch_Taken), .Branch_Disp(Branch_Disp), .Busy(Busy),
      .Halted(Halted), .Issue_Count(Issue_Count)
   );

   fetch_sequencer #(.RESET_PC(32'hFFFFFFFF)) dut_w (
      .CLOCK_50(CLOCK_50), .RESET_InHigh(RESET_InHigh), .Fetch_Start(start_w),
      .BusDirecciones(bus_w), .BusDatos(dat_w), .Instr_Out(instr_w),
      .PC_Out(pc_w), .Instr_Valid(valid_w), .Instr_Ready(1'b1),
      .Branch_Taken(1'b0), .Branch_Disp(32'h0), .Busy(busy_w),
      .Halted(halted_w), .Issue_Count(count_w)
   );

   task automatic test_reset();
      #2 RESET_InHigh = 1'b1;
      #1;
      chk++; if (BusDirecciones !== 32'h800) begin fail++; $display("FAIL rst_addr got=%h exp=00000800", BusDirecciones); end
      chk++; if (Instr_Valid !== 1'b0) begin fail++; $display("FAIL rst_valid got=%b exp=0", Instr_Valid); end
      chk++; if (Halted !== 1'b0 || Busy !== 1'b0) begin fail++; $display("FAIL rst_flags got=%b%b exp=00", Halted, Busy); end
      chk++; if (Issue_Count !== 16'h0) begin fail++; $display("FAIL rst_count got=%0d exp=0", Issue_Count); end
      chk++; if (PC_Out !== 32'h800 || Instr_Out !== 32'h0) begin fail++; $display("FAIL rst_out got=%h/%h exp=00000800/00000000", PC_Out, Instr_Out); end
      repeat (2) @(negedge CLOCK_50);
      RESET_InHigh = 1'b0;
      repeat (2) @(negedge CLOCK_50);
      chk++; if (Busy !== 1'b0 || Instr_Valid !== 1'b0) begin fail++; $display("FAIL rst_idle got=%b%b exp=00", Busy, Instr_Valid); end
   endtask

   task automatic test_linear();
      Instr_Ready = 1'b1;
      Fetch_Start = 1'b1;
      @(negedge CLOCK_50);
      Fetch_Start = 1'b0;
      chk++; if (Busy !== 1'b1 || Instr_Valid !== 1'b0 || BusDirecciones !== 32'h800) begin
         fail++; $display("FAIL lin_fetch0 got busy=%b valid=%b addr=%h exp 1 0 00000800", Busy, Instr_Valid, BusDirecciones); end
      for (int k = 0; k < 7; k++) begin
         @(negedge CLOCK_50);
         chk++; if (Instr_Valid !== 1'b1 || PC_Out !== 32'h800 + k || Instr_Out !== mem_word(32'h800 + k)) begin
            fail++; $display("FAIL lin_issue k=%0d got valid=%b pc=%h ir=%h exp 1 %h %h", k, Instr_Valid, PC_Out, Instr_Out, 32'h800 + k, mem_word(32'h800 + k)); end
         @(negedge CLOCK_50);
         chk++; if (Instr_Valid !== 1'b0 || BusDirecciones !== 32'h801 + k) begin
            fail++; $display("FAIL lin_fetch k=%0d got valid=%b addr=%h exp 0 %h", k, Instr_Valid, BusDirecciones, 32'h801 + k); end
      end
      chk++; if (Issue_Count !== 16'd7) begin fail++; $display("FAIL lin_count got=%0d exp=7", Issue_Count); end
   endtask

   task automatic test_branch();
      @(negedge CLOCK_50);
      chk++; if (PC_Out !== 32'h807 || Instr_Valid !== 1'b1) begin fail++; $display("FAIL br1_pc got=%h exp=00000807", PC_Out); end
      Branch_Taken = 1'b1; Branch_Disp = 32'hFFFFFFFC;
      @(negedge CLOCK_50);
      chk++; if (BusDirecciones !== 32'h803) begin fail++; $display("FAIL br1_target got=%h exp=00000803", BusDirecciones); end
      Branch_Taken = 1'b0; Branch_Disp = 32'h00000040;
      for (int a = 32'h803; a <= 32'h80C; a++) begin
         @(negedge CLOCK_50);
         chk++; if (PC_Out !== 32'(a)) begin fail++; $display("FAIL br_run_pc got=%h exp=%h", PC_Out, 32'(a)); end
         @(negedge CLOCK_50);
         chk++; if (BusDirecciones !== 32'(a + 1)) begin fail++; $display("FAIL br_run_addr got=%h exp=%h", BusDirecciones, 32'(a + 1)); end
      end
      @(negedge CLOCK_50);
      chk++; if (PC_Out !== 32'h80D) begin fail++; $display("FAIL br2_pc got=%h exp=0000080d", PC_Out); end
      Branch_Taken = 1'b1; Branch_Disp = 32'hFFFFFFFB;
      @(negedge CLOCK_50);
      chk++; if (BusDirecciones !== 32'h808) begin fail++; $display("FAIL br2_target got=%h exp=00000808", BusDirecciones); end
      Branch_Taken = 1'b0;
      chk++; if (Issue_Count !== 16'd19) begin fail++; $display("FAIL br_count got=%0d exp=19", Issue_Count); end
   endtask

   task automatic test_backpressure();
      @(negedge CLOCK_50);
      chk++; if (PC_Out !== 32'h808 || Instr_Valid !== 1'b1) begin fail++; $display("FAIL bp_entry got pc=%h valid=%b exp 00000808 1", PC_Out, Instr_Valid); end
      Instr_Ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         Branch_Taken = (i != 1);
         Branch_Disp = 32'h00000100;
         Fetch_Start = (i == 2);
         @(negedge CLOCK_50);
         chk++; if (Instr_Valid !== 1'b1 || PC_Out !== 32'h808 || Instr_Out !== mem_word(32'h808)
                     || BusDirecciones !== 32'h808 || Issue_Count !== 16'd19) begin
            fail++; $display("FAIL bp_hold i=%0d got valid=%b pc=%h ir=%h addr=%h cnt=%0d", i, Instr_Valid, PC_Out, Instr_Out, BusDirecciones, Issue_Count); end
      end
      Fetch_Start = 1'b0; Branch_Taken = 1'b0; Instr_Ready = 1'b1;
      @(negedge CLOCK_50);
      chk++; if (BusDirecciones !== 32'h809 || Issue_Count !== 16'd20) begin
         fail++; $display("FAIL bp_release got addr=%h cnt=%0d exp 00000809 20", BusDirecciones, Issue_Count); end
   endtask

   task automatic test_halt_restart();
      for (int a = 32'h809; a <= 32'h80D; a++) begin
         @(negedge CLOCK_50);
         chk++; if (PC_Out !== 32'(a) || Instr_Valid !== 1'b1) begin fail++; $display("FAIL halt_run_pc got=%h exp=%h", PC_Out, 32'(a)); end
         @(negedge CLOCK_50);
      end
      chk++; if (BusDirecciones !== 32'h80E || Busy !== 1'b1) begin fail++; $display("FAIL halt_fetch got addr=%h busy=%b exp 0000080e 1", BusDirecciones, Busy); end
      for (int i = 0; i < 3; i++) begin
         @(negedge CLOCK_50);
         chk++; if (Halted !== 1'b1 || Busy !== 1'b0 || Instr_Valid !== 1'b0 || BusDirecciones !== 32'h80E
                     || PC_Out !== 32'h80D || Issue_Count !== 16'd25) begin
            fail++; $display("FAIL halt_state i=%0d got h=%b b=%b v=%b addr=%h pc=%h cnt=%0d", i, Halted, Busy, Instr_Valid, BusDirecciones, PC_Out, Issue_Count); end
      end
      Fetch_Start = 1'b1;
      @(negedge CLOCK_50);
      Fetch_Start = 1'b0;
      chk++; if (BusDirecciones !== 32'h800 || Issue_Count !== 16'd0 || Halted !== 1'b0 || Busy !== 1'b1 || Instr_Valid !== 1'b0) begin
         fail++; $display("FAIL restart_fetch got addr=%h cnt=%0d h=%b b=%b v=%b", BusDirecciones, Issue_Count, Halted, Busy, Instr_Valid); end
      @(negedge CLOCK_50);
      chk++; if (Instr_Valid !== 1'b1 || PC_Out !== 32'h800) begin fail++; $display("FAIL restart_issue got valid=%b pc=%h exp 1 00000800", Instr_Valid, PC_Out); end
   endtask

   task automatic test_async_reset_issue();
      @(negedge CLOCK_50);
      chk++; if (Issue_Count !== 16'd1) begin fail++; $display("FAIL ar_count_pre got=%0d exp=1", Issue_Count); end
      Instr_Ready = 1'b0;
      @(negedge CLOCK_50);
      chk++; if (Instr_Valid !== 1'b1 || PC_Out !== 32'h801) begin fail++; $display("FAIL ar_issue got valid=%b pc=%h exp 1 00000801", Instr_Valid, PC_Out); end
      #2 RESET_InHigh = 1'b1;
      #1;
      chk++; if (Instr_Valid !== 1'b0 || Busy !== 1'b0 || Issue_Count !== 16'd0 || BusDirecciones !== 32'h800
                  || PC_Out !== 32'h800 || Instr_Out !== 32'h0) begin
         fail++; $display("FAIL ar_mid got v=%b b=%b cnt=%0d addr=%h pc=%h ir=%h", Instr_Valid, Busy, Issue_Count, BusDirecciones, PC_Out, Instr_Out); end
      @(negedge CLOCK_50);
      RESET_InHigh = 1'b0;
      Instr_Ready = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      chk++; if (Busy !== 1'b0 || Instr_Valid !== 1'b0) begin fail++; $display("FAIL ar_idle got b=%b v=%b exp 0 0", Busy, Instr_Valid); end
   endtask

   task automatic test_wrap();
      start_w = 1'b1;
      @(negedge CLOCK_50);
      start_w = 1'b0;
      chk++; if (bus_w !== 32'hFFFFFFFF || busy_w !== 1'b1) begin fail++; $display("FAIL wrap_fetch got addr=%h busy=%b exp ffffffff 1", bus_w, busy_w); end
      @(negedge CLOCK_50);
      chk++; if (valid_w !== 1'b1 || pc_w !== 32'hFFFFFFFF || instr_w !== mem_word(32'hFFFFFFFF)) begin
         fail++; $display("FAIL wrap_issue got v=%b pc=%h ir=%h", valid_w, pc_w, instr_w); end
      @(negedge CLOCK_50);
      chk++; if (bus_w !== 32'h0) begin fail++; $display("FAIL wrap_addr got=%h exp=00000000", bus_w); end
      @(negedge CLOCK_50);
      chk++; if (valid_w !== 1'b1 || pc_w !== 32'h0 || count_w !== 16'd1) begin
         fail++; $display("FAIL wrap_next got v=%b pc=%h cnt=%0d exp 1 00000000 1", valid_w, pc_w, count_w); end
   endtask

   initial begin
      test_reset();
      test_linear();
      test_branch();
      test_backpressure();
      test_halt_restart();
      test_async_reset_issue();
      test_wrap();
      $display("TB_RESULT checks=%0d failures=%0d", chk, fail);
      $finish;
   end

endmodule
